// File: rtl/fpmul_arb_pkg.sv
// Shared widths, latency and tag type for the multiplier arbiter slice.
package fpmul_arb_pkg;

  localparam int FP_W     = 32;
  localparam int MUL_LAT  = 2;
  // Widest requester index needed for NUM_REQ up to 8.
  localparam int TAG_ID_W = 3;

  // One tag per multiplier stage: valid bit plus the issuing requester.
  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // Requester-index width: never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fpmul_mult.sv
// Two-stage single-precision multiplier: operands registered, then product
// registered. Truncating mantissa, zero operands give a signed zero, no
// NaN/Inf/denormal/overflow handling. No reset on the datapath.
module FPMultiplier
  import fpmul_arb_pkg::*;
(
  input  logic            clk,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] result
);

  logic [FP_W-1:0] a_q, b_q;
  logic [FP_W-1:0] res_q, res_d;
  logic            sign;
  logic            is_zero;
  logic [47:0]     prod;
  logic [9:0]      exp_sum;
  logic [9:0]      exp_adj;
  logic [22:0]     mant;

  // Product of the registered operands with single-bit normalisation.
  always_comb begin
    sign    = a_q[31] ^ b_q[31];
    is_zero = (a_q[30:0] == 31'd0) || (b_q[30:0] == 31'd0);
    prod    = 48'({1'b1, a_q[22:0]}) * 48'({1'b1, b_q[22:0]});
    exp_sum = {2'b00, a_q[30:23]} + {2'b00, b_q[30:23]} - 10'd127;
    if (prod[47]) begin
      exp_adj = exp_sum + 10'd1;
      mant    = prod[46:24];
    end else begin
      exp_adj = exp_sum;
      mant    = prod[45:23];
    end
    res_d = is_zero ? {sign, 31'd0} : {sign, exp_adj[7:0], mant};
  end

  // Pipeline registers: stage 1 operands, stage 2 product.
  always_ff @(posedge clk) begin
    a_q   <= a;
    b_q   <= b;
    res_q <= res_d;
  end

  // Registered result.
  always_comb begin
    result = res_q;
  end

endmodule

// File: rtl/fpmul_resp_fifo.sv
// Circular response FIFO. Exposes its occupancy for the upstream credit check.
// Reads return zero while empty so the consumer never sees stale data.
module fpmul_resp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 34,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [W-1:0]     rd_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic             full;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer, count and storage next-state; a push while full is only taken
  // when the head leaves in the same cycle.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    pop      = rd_en && (count_q != '0);
    push     = wr_en && (!full || pop);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
    end
  end

  // Control state; reset discards every stored entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array carries no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head output, forced to zero while empty.
  always_comb begin
    rd_valid = (count_q != '0);
    rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    count    = count_q;
  end

endmodule

// File: rtl/fpmul_arbiter.sv
// Round-robin front end sharing one pipelined FP multiplier among NUM_REQ
// clients. Results are tagged with the requester index and queued in a
// bounded FIFO; a credit check keeps the non-stallable multiplier from
// overrunning that FIFO.
//
// Handshakes: a request transfers at a rising edge where req_valid[i] and
// req_ready[i] are both high; a response transfers at an edge where
// resp_valid and resp_ready are both high. req_ready is combinational from
// req_valid and internal state, and is at most one-hot.
module fpmul_arbiter
  import fpmul_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int OUT_DEPTH = 4,
  localparam int ID_W      = id_width(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [FP_W-1:0]         resp_data,
  output logic                    busy
);

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int SUM_W = CNT_W + 2;

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  tag_t             tag_q [MUL_LAT];
  tag_t             tag_d [MUL_LAT];
  logic [CNT_W-1:0] fifo_count;
  logic [SUM_W-1:0] inflight;
  logic             credit_ok;
  logic             grant_any;
  logic [ID_W-1:0]  grant_idx;
  logic [FP_W-1:0]  mul_a, mul_b;
  logic [FP_W-1:0]  mul_result;
  logic             fifo_wr;
  logic [ID_W+FP_W-1:0] fifo_wr_data;
  logic [ID_W+FP_W-1:0] fifo_rd_data;
  logic             unused_tag_bits;

  // Conservative credit: everything in the multiplier plus everything queued
  // must fit; a pop this cycle is not counted.
  always_comb begin
    inflight = SUM_W'(fifo_count);
    for (int s = 0; s < MUL_LAT; s++) begin
      inflight = inflight + SUM_W'(tag_q[s].v);
    end
    credit_ok = (inflight < SUM_W'(OUT_DEPTH));
  end

  // Round-robin search from rr_ptr; the first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && credit_ok && !rst &&
          req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
    req_ready = '0;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Pointer advances past the winner; operand mux defaults to requester 0.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
    mul_a = req_a[int'(grant_idx)*FP_W +: FP_W];
    mul_b = req_b[int'(grant_idx)*FP_W +: FP_W];
  end

  // Tag pipeline mirrors the multiplier latency; the last stage writes the FIFO.
  always_comb begin
    tag_d[0].v  = grant_any;
    tag_d[0].id = TAG_ID_W'(grant_idx);
    for (int s = 1; s < MUL_LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end
    fifo_wr         = tag_q[MUL_LAT-1].v;
    fifo_wr_data    = {tag_q[MUL_LAT-1].id[ID_W-1:0], mul_result};
    unused_tag_bits = ^tag_q[MUL_LAT-1].id;
  end

  // Arbiter pointer and tag registers; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tag_q    <= tag_d;
    end
  end

  FPMultiplier u_mul (
    .clk    (clk),
    .a      (mul_a),
    .b      (mul_b),
    .result (mul_result)
  );

  fpmul_resp_fifo #(
    .DEPTH (OUT_DEPTH),
    .W     (ID_W + FP_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fifo_wr),
    .wr_data  (fifo_wr_data),
    .rd_en    (resp_ready),
    .rd_valid (resp_valid),
    .rd_data  (fifo_rd_data),
    .count    (fifo_count)
  );

  // Response split and activity flag.
  always_comb begin
    {resp_id, resp_data} = fifo_rd_data;
    busy = (fifo_count != '0);
    for (int s = 0; s < MUL_LAT; s++) begin
      busy = busy | tag_q[s].v;
    end
  end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Randomised and directed bench for fpmul_arbiter with a queue-based model.
module tb_fpmul_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int OUT_DEPTH = 4;
  localparam int ID_W      = 2;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_data;
  logic                  busy;

  fpmul_arbiter #(.NUM_REQ(NUM_REQ), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: accepted-but-not-popped operations in acceptance order,
  // with the edge number after which each becomes visible.
  logic [ID_W+31:0] exp_q[$];
  int               vis_q[$];
  int               rr;
  int               edge_n;
  int               dut_grants;
  int               n_vec;
  int               n_miss;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference product computed from real-number rules with integer math.
  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    longint unsigned   ma, mb, p;
    int                e;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    ma = 64'(1 << 23) | 64'(a[22:0]);
    mb = 64'(1 << 23) | 64'(b[22:0]);
    p  = ma * mb;                        // value = p / 2^46
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p >= (64'd1 << 47)) begin
      e = e + 1;
      p = p >> 1;
    end
    return {s, 8'(e), 23'(p >> 23)};
  endfunction

  function automatic logic [31:0] rnd_fp();
    if ($urandom_range(0, 9) == 0) return {1'($urandom_range(0, 1)), 31'd0};
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  // One clock: compare at the falling edge, update model at the rising edge.
  task automatic step();
    logic [NUM_REQ-1:0] exp_ready;
    int                 g;
    int                 j;
    logic               vis;
    @(negedge clk);
    exp_ready = '0;
    g = -1;
    if (exp_q.size() < OUT_DEPTH) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (rr + k) % NUM_REQ;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (req_ready != '0) dut_grants++;
    vis = (exp_q.size() > 0) && (vis_q[0] <= edge_n);
    check("resp_valid", 64'(resp_valid), 64'(vis));
    check("resp_id", 64'(resp_id), vis ? 64'(exp_q[0][ID_W+31:32]) : 64'd0);
    check("resp_data", 64'(resp_data), vis ? 64'(exp_q[0][31:0]) : 64'd0);
    check("busy", 64'(busy), 64'(exp_q.size() != 0));
    check("fifo_bound", 64'(int'(dut.fifo_count) <= OUT_DEPTH), 64'd1);
    @(posedge clk);
    edge_n++;
    if (vis && resp_ready) begin
      void'(exp_q.pop_front());
      void'(vis_q.pop_front());
    end
    if (g >= 0) begin
      exp_q.push_back({ID_W'(g), fp_ref(req_a[g*32 +: 32], req_b[g*32 +: 32])});
      vis_q.push_back(edge_n + 2);
      rr = (g + 1) % NUM_REQ;
    end
    #1;
  endtask

  // Single isolated operation with an explicit 3-cycle latency check.
  task automatic directed(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input string tag);
    set_op(i, a, b);
    req_valid  = '0;
    req_valid[i] = 1'b1;
    resp_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    step();
    check({tag, "_valid"}, 64'(resp_valid), 64'd1);
    check({tag, "_data"}, 64'(resp_data), 64'(expv));
    check({tag, "_id"}, 64'(resp_id), 64'(i));
    step();
  endtask

  // Stimulus and report
  initial begin
    int g0;
    n_vec = 0; n_miss = 0; rr = 0; edge_n = 0; dut_grants = 0;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    #3;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_id", 64'(resp_id), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    // Basic product and special operands
    directed(0, 32'h40400000, 32'h40000000, 32'h40C00000, "basic");
    directed(1, 32'h00000000, 32'h40400000, 32'h00000000, "zero");
    directed(2, 32'hC0000000, 32'h40400000, 32'hC0C00000, "neg");
    directed(3, 32'h80000000, 32'h40400000, 32'h80000000, "negzero");

    // Round-robin fairness at full rate
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'h3FC00000, 32'h3FC00000);
    req_valid = '1; resp_ready = 1'b1;
    g0 = dut_grants;
    for (int c = 0; c < 12; c++) step();
    check("rr_throughput", 64'(dut_grants - g0), 64'd12);
    req_valid = '0;
    for (int c = 0; c < 6; c++) step();

    // Backpressure: exactly OUT_DEPTH grants, then drain and resume
    for (int i = 0; i < NUM_REQ; i++) set_op(i, rnd_fp(), rnd_fp());
    req_valid = '1; resp_ready = 1'b0;
    g0 = dut_grants;
    for (int c = 0; c < 10; c++) step();
    check("bp_grants", 64'(dut_grants - g0), 64'(OUT_DEPTH));
    resp_ready = 1'b1;
    g0 = dut_grants;
    for (int c = 0; c < 6; c++) step();
    check("bp_resume", 64'((dut_grants - g0) > 0), 64'd1);
    req_valid = '0;
    for (int c = 0; c < 6; c++) step();

    // Reset mid-flight
    req_valid = '1;
    step(); step(); step();
    #1 rst = 1'b1;
    #1;
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check("midrst_resp_id", 64'(resp_id), 64'd0);
    check("midrst_resp_data", 64'(resp_data), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    exp_q.delete(); vis_q.delete(); rr = 0;
    @(posedge clk); edge_n++;
    #2 rst = 1'b0;
    step(); step();
    req_valid = '0;
    for (int c = 0; c < 6; c++) step();

    // Sparse requests from requester 2 only
    for (int c = 0; c < 8; c++) begin
      set_op(2, rnd_fp(), rnd_fp());
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      step();
    end
    for (int c = 0; c < 4; c++) step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) set_op(i, rnd_fp(), rnd_fp());
      req_valid  = NUM_REQ'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0; resp_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fpmul_arbiter.md
# fpmul_arbiter

Shares one pipelined single-precision `FPMultiplier` among `NUM_REQ` requesters. Arbitration is round-robin, and each requester uses a valid/ready handshake. Every issued operation is tagged with its requester ID. Results go into a bounded response FIFO, and a credit check stops the non-stallable multiplier from overflowing it. The block sits between the compute clients and the single multiplier instance, which it owns.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, from 2 to 8.
- `OUT_DEPTH`, default 4: number of response FIFO entries, at least 2. Full throughput needs at least 4.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req_valid`  in  `NUM_REQ`: one request-valid bit per requester.
- `req_ready`  out  `NUM_REQ`: one-hot grant. Combinational from `req_valid` and the arbiter state.
- `req_a`  in  `NUM_REQ*32`: operand A. Requester i uses bits `[32i+31:32i]`.
- `req_b`  in  `NUM_REQ*32`: operand B, packed the same way as `req_a`.
- `resp_valid`  out  1: the FIFO head is valid.
- `resp_ready`  in  1: the consumer accepts the head.
- `resp_id`  out  `ID_W`: requester index of the head. `ID_W` = max(1, clog2(`NUM_REQ`)).
- `resp_data`  out  32: IEEE-754 product at the head.
- `busy`  out  1: high while any operation is in flight or the FIFO is non-empty.

## Operation
- **Grant rule.**
  - Requester i is granted when `req_valid[i]` is high, `rst` is low, and credit is available.
  - Among valid requesters, the grant goes to the first one at or after `rr_ptr`, searching modulo `NUM_REQ`.
  - At most one grant per cycle.
- **Credit.** Credit is available when `fifo_count + s1_v + s2_v < OUT_DEPTH`.
  - A pop in the same cycle does not add credit; the check is deliberately conservative.
- **Round-robin pointer.** On acceptance by requester g, `rr_ptr` becomes (g+1) mod `NUM_REQ`. With no acceptance, it holds.
- **Multiplier input.** The multiplier operands come from a mux on the granted index. With no grant, the mux drives requester 0; the result is ignored because no tag is set.
- **Tag pipeline.** Stages s1 and s2 each hold `{v, id}` and track the multiplier's 2-cycle latency.
  - s1 ← {grant_any, grant_idx}.
  - s2 ← s1.
  - When `s2_v` is set, the FIFO writes {s2_id, multiplier result}.
- **FIFO.** Circular buffer with read/write pointers and a count.
  - A write and a pop in the same cycle are both legal; the count is unchanged.
  - A write while full cannot happen because of the credit check. Verification asserts this.
- **Empty FIFO outputs.** While the FIFO is empty, `resp_data` = 0 and `resp_id` = 0.
- **Arithmetic.** Inherited unchanged from `FPMultiplier`:
  - the mantissa is truncated, with no rounding;
  - a zero operand (bits `[30:0]` = 0) gives exponent and mantissa 0, and the sign is still the XOR of the input signs;
  - there is no handling of NaN, Inf, denormals, or overflow.

## Timing
- **Reset values.** `req_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_data`=0, `busy`=0, `rr_ptr`=0. Both tag valid bits and `fifo_count` are 0.
- **Multiplier has no reset.** Its registers are don't-care after reset.
- **Reset mid-operation.** In-flight operations and FIFO contents are discarded, and no response is emitted for them.
- **Acceptance.** A transfer completes at edge k when `req_valid[i]` and `req_ready[i]` are both high. Operands must be stable in the cycle before edge k.
- **Latency.**
  - s1 is set at edge k.
  - The product is registered in the multiplier and s2 is set at edge k+1.
  - The FIFO is written at edge k+2.
  - `resp_valid` is high in the cycle after edge k+2, so minimum latency is 3 cycles.
- **Throughput.** One operation per cycle when `resp_ready` is held at 1 and `OUT_DEPTH` ≥ 4.
- **Ordering.** Responses come out in acceptance order, across all requesters.
- **Output stability.** While `resp_valid` is high and `resp_ready` is low, the head is held stable.
- **Pop.** The head is popped at the edge where `resp_valid` and `resp_ready` are both high.
- **Busy.** `busy` = `s1_v` | `s2_v` | (`fifo_count` != 0).

## Structure
- **Package `fpmul_arb_pkg`** holds:
  - `FP_W`=32;
  - `MUL_LAT`=2;
  - the tag struct `{logic v; logic [ID_W-1:0] id;}`;
  - a function computing `ID_W` from `NUM_REQ`.
- **Sub-module `fpmul_resp_fifo`**: a synchronous FIFO with parameters `DEPTH` and `W` = `ID_W`+32.
  - It exports `count` for the credit logic.
  - It uses the same `clk` and `rst`.
- **Top level** contains the arbiter, the tag pipeline, and the instance of `FPMultiplier`.

## Test plan
- **Basic product.** Requester 0 sends a=0x40400000, b=0x40000000 at edge k → `resp_valid` in the cycle after edge k+2, `resp_data`=0x40C00000, `resp_id`=0.
- **Round-robin fairness.** All 4 requesters hold valid with 1.5×1.5 (0x3FC00000), and `resp_ready`=1.
  - Grants go 0,1,2,3,0,… with one per cycle.
  - Every response is 0x40100000, with IDs in grant order.
- **Special operands.**
  - 0x00000000 × 0x40400000 → 0x00000000.
  - 0xC0000000 × 0x40400000 → 0xC0C00000.
  - 0x80000000 × 0x40400000 → 0x80000000.
- **Backpressure.** `resp_ready`=0 and all requesters valid.
  - Exactly `OUT_DEPTH` grants occur, then `req_ready` stays 0.
  - Assert no FIFO overflow and that the head stays stable.
  - Raise `resp_ready` → responses drain in order and grants resume.
- **Reset mid-flight.** Assert `rst` one cycle after 2 acceptances.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, no stale responses appear and `rr_ptr` restarts at 0.
- **Sparse requests.** Only requester 2 is valid, on alternating cycles → each request is granted on its first cycle, with `rr_ptr` moving to 3 and then wrapping back to select 2.
